multibuffer_pack_queue: RTL

- Width-up packing queue: accepts narrow DATA_IN_WIDTH words and packs RATIO = Q_DATA_WIDTH/DATA_IN_WIDTH consecutive words into one Q_DATA_WIDTH line.
- Stores lines in an internal M_BUFF_NUM x 2^M_BUFF_ADDR_WIDTH line store and returns them as whole lines.
- Serves as the producer-side counterpart of the team's wide-write/narrow-read multibuffer queue, for upsizing narrow packet streams onto wide datapaths.

---
 rtl/multibuffer_pack_queue_if.sv | 37 +++
 rtl/multibuffer_pack_queue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multibuffer_pack_queue_if.sv
// ---------------------------------------------------------------------------
// multibuffer_pack_queue_if
// Bus bundle for the width-up packing queue.
//   write_en / data_in / flush   : producer side, narrow words in
//   waitrequest                  : producer back-pressure (write_en, flush ignored)
//   read_en / data_out / data_valid : consumer side, whole lines out
//   full / empty / almost_full / partial : queue status
// Modports:
//   master : the agent driving the queue (producer + consumer)
//   slave  : the queue itself
// ---------------------------------------------------------------------------
interface multibuffer_pack_queue_if #(
    parameter int Q_DATA_WIDTH  = 128,
    parameter int DATA_IN_WIDTH = 64
);
    logic                     write_en;
    logic [DATA_IN_WIDTH-1:0] data_in;
    logic                     flush;
    logic                     waitrequest;
    logic                     read_en;
    logic [Q_DATA_WIDTH-1:0]  data_out;
    logic                     data_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     partial;

    modport master (
        output write_en, data_in, flush, read_en,
        input  waitrequest, data_out, data_valid, full, empty, almost_full, partial
    );

    modport slave (
        input  write_en, data_in, flush, read_en,
        output waitrequest, data_out, data_valid, full, empty, almost_full, partial
    );
endinterface

// File: rtl/multibuffer_pack_queue.sv
// ---------------------------------------------------------------------------
// multibuffer_pack_queue
// Packs RATIO consecutive DATA_IN_WIDTH words (little-endian, first word in
// the low lane) into Q_DATA_WIDTH lines, stores them in a
// M_BUFF_NUM x 2^M_BUFF_ADDR_WIDTH line store and returns whole lines.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : multibuffer_pack_queue_if.slave (write/flush/read handshake,
//          popped line, status flags)
// Read latency is 2 cycles from an accepted read_en to data_valid.
// ---------------------------------------------------------------------------
module multibuffer_pack_queue #(
    parameter int Q_DATA_WIDTH      = 128,
    parameter int DATA_IN_WIDTH     = 64,
    parameter int M_BUFF_NUM        = 4,
    parameter int M_BUFF_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    multibuffer_pack_queue_if.slave   bus
);
    localparam int RATIO       = Q_DATA_WIDTH / DATA_IN_WIDTH;
    localparam int LANE_W      = $clog2(RATIO);
    localparam int BLOCK_LINES = 2 ** M_BUFF_ADDR_WIDTH;
    localparam int DEPTH       = M_BUFF_NUM * BLOCK_LINES;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int PTR_W       = ADDR_W + 1;

    localparam logic [PTR_W-1:0]  AF_LEVEL  = PTR_W'(DEPTH - BLOCK_LINES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [Q_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [Q_DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                    rd_pend_q;
    logic                    data_valid_q;
    logic [Q_DATA_WIDTH-1:0] rd_line_q;

    logic [Q_DATA_WIDTH-1:0] store_mem [DEPTH];

    logic                    empty_c;
    logic                    full_c;
    logic [PTR_W-1:0]        count_c;
    logic                    word_acc;
    logic                    flush_acc;
    logic                    commit;
    logic                    rd_acc;
    logic [Q_DATA_WIDTH-1:0] merged;

    // Status flags come straight from the registered pointers, so a line
    // committed this cycle is not readable until the next one.
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign count_c = wr_ptr_q - rd_ptr_q;

    assign word_acc  = bus.write_en && !full_c;
    assign flush_acc = bus.flush && !full_c && ((lane_q != '0) || bus.write_en);
    assign commit    = (word_acc && (lane_q == LAST_LANE)) || flush_acc;
    // Empty gates reads, so the read address never equals a write address.
    assign rd_acc    = bus.read_en && !empty_c;

    // Pack register with this cycle's word dropped into its lane; unfilled
    // upper lanes are already zero because the register clears on commit.
    always_comb begin
        merged = pack_q;
        if (word_acc) begin
            merged[int'(lane_q) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = bus.data_in;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        data_out_d = data_out_q;
        if (commit) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            lane_d   = '0;
            pack_d   = '0;
        end else if (word_acc) begin
            lane_d = lane_q + 1'b1;
            pack_d = merged;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (rd_pend_q) begin
            data_out_d = rd_line_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lane_q       <= '0;
            pack_q       <= '0;
            data_out_q   <= '0;
            rd_pend_q    <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            data_out_q   <= data_out_d;
            rd_pend_q    <= rd_acc;
            data_valid_q <= rd_pend_q;
        end
    end

    // Line store: no reset so it maps onto a synchronous RAM with a
    // registered read port.
    always_ff @(posedge clk) begin
        if (commit) begin
            store_mem[wr_ptr_q[ADDR_W-1:0]] <= merged;
        end
        if (rd_acc) begin
            rd_line_q <= store_mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign bus.waitrequest = full_c;
    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.almost_full = (count_c >= AF_LEVEL);
    assign bus.partial     = (lane_q != '0);
    assign bus.data_out    = data_out_q;
    assign bus.data_valid  = data_valid_q;

endmodule
